// File: rtl/hr_xfer_fifo_bank_pkg.sv
// Shared constants for the hierarchical-ring transfer-buffer bank: channel indices and flit geometry.
// The flit width and valid-bit position come from defines.v when that file is compiled first.
`ifndef HR_CONTROL_N
`define HR_CONTROL_N 16
`endif
`ifndef HR_VALID_F
`define HR_VALID_F 15
`endif

package hr_xfer_fifo_bank_pkg;
  localparam int NUM_CH  = 4;
  localparam int CH_L0   = 0;
  localparam int CH_L1   = 1;
  localparam int CH_G0   = 2;
  localparam int CH_G1   = 3;
  localparam int FLIT_W  = `HR_CONTROL_N;
  localparam int VALID_F = `HR_VALID_F;
endpackage

// File: rtl/hr_xfer_fifo_bank_if.sv
// Bridge-to-bank bus: per-channel enqueue/dequeue strobes, head flits, full flags, errors and statistics.
interface hr_xfer_fifo_bank_if #(
  parameter int STAT_W = 8
);
  import hr_xfer_fifo_bank_pkg::*;

  // enQ_i/deQ_i are single-cycle strobes with no ready. bfull_o is the only backpressure: the
  // bridge must not raise enQ_i on a full channel unless it raises deQ_i on it in the same cycle.
  logic [NUM_CH*FLIT_W-1:0] fifo_d_i;
  logic [NUM_CH-1:0]        enQ_i;
  logic [NUM_CH-1:0]        deQ_i;
  logic [NUM_CH*FLIT_W-1:0] fifo_q_o;
  logic [NUM_CH-1:0]        bfull_o;
  logic [NUM_CH-1:0]        err_o;
  logic [NUM_CH*STAT_W-1:0] hwm_o;
  logic [NUM_CH*STAT_W-1:0] drop_o;

  modport master (
    output fifo_d_i, enQ_i, deQ_i,
    input  fifo_q_o, bfull_o, err_o, hwm_o, drop_o
  );

  modport slave (
    input  fifo_d_i, enQ_i, deQ_i,
    output fifo_q_o, bfull_o, err_o, hwm_o, drop_o
  );
endinterface

// File: rtl/hr_xfer_fifo_bank_fifo.sv
// One show-ahead transfer FIFO channel with sticky protocol error.
// With HR_FIFO_STATS_EN defined it also keeps a high-water mark and a saturating drop counter.
module hr_xfer_fifo
  import hr_xfer_fifo_bank_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int STAT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] d,
  input  logic              enq,
  input  logic              deq,
  output logic [FLIT_W-1:0] q,
  output logic              bfull,
  output logic              err,
  output logic [STAT_W-1:0] hwm,
  output logic [STAT_W-1:0] drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count, count_nxt;
  logic              is_empty, is_full, push, pop, ovf, proto_err;

  always_comb begin
    is_empty  = (count == '0);
    is_full   = (count == FULL_CNT);
    // A full channel still accepts a push when it pops in the same cycle (bridge swap).
    push      = enq & d[VALID_F] & (~is_full | deq);
    pop       = deq & ~is_empty;
    ovf       = enq & is_full & ~deq;
    proto_err = ovf | (deq & is_empty) | (enq & ~d[VALID_F]);
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CNT_ONE;
    end else if (pop && !push) begin
      count_nxt = count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
      if (proto_err) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= d;
  end

  assign q     = is_empty ? '0 : mem[rd_ptr];
  assign bfull = is_full;

`ifdef HR_FIFO_STATS_EN
  localparam logic [STAT_W-1:0] STAT_ONE = 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      hwm  <= '0;
      drop <= '0;
    end else begin
      if (STAT_W'(count_nxt) > hwm) hwm <= STAT_W'(count_nxt);
      if (ovf && drop != '1) drop <= drop + STAT_ONE;
    end
  end
`else
  assign hwm  = '0;
  assign drop = '0;
`endif
endmodule

// File: rtl/hr_xfer_fifo_bank.sv
// Transfer-buffer bank for the 4-port hierarchical-ring bridge: one independent FIFO per port (l0,l1,g0,g1).
// Optional statistics (hwm_o, drop_o) are built only when HR_FIFO_STATS_EN is defined.
module hr_xfer_fifo_bank
  import hr_xfer_fifo_bank_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int STAT_W = 8
) (
  input logic                clk,
  input logic                rst,
  hr_xfer_fifo_bank_if.slave bus
);
  logic [NUM_CH-1:0][FLIT_W-1:0] q_w;
  logic [NUM_CH-1:0][STAT_W-1:0] hwm_w, drop_w;
  logic [NUM_CH-1:0]             bfull_w, err_w;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    hr_xfer_fifo #(
      .DEPTH  (DEPTH),
      .STAT_W (STAT_W)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .d     (bus.fifo_d_i[c*FLIT_W +: FLIT_W]),
      .enq   (bus.enQ_i[c]),
      .deq   (bus.deQ_i[c]),
      .q     (q_w[c]),
      .bfull (bfull_w[c]),
      .err   (err_w[c]),
      .hwm   (hwm_w[c]),
      .drop  (drop_w[c])
    );
  end

  assign bus.fifo_q_o = q_w;
  assign bus.bfull_o  = bfull_w;
  assign bus.err_o    = err_w;
  assign bus.hwm_o    = hwm_w;
  assign bus.drop_o   = drop_w;
endmodule
